jtag_ir_dr_shifter: RTL

//  JTAG instruction/data register path, directly downstream of the TAP controller FSM.

---
 rtl/jtag_ir_dr_shifter.sv | 104 ++++++++++
 1 files changed

// File: rtl/jtag_ir_dr_shifter.sv
// JTAG instruction/data register path behind the TAP controller: IR, BYPASS/IDCODE/USER
// data registers, negedge TDO stage and the parallel user register handed to core logic.
module jtag_ir_dr_shifter #(
  parameter int          IR_WIDTH     = 4,
  parameter logic [31:0] IDCODE_VALUE = 32'h1234_5001,
  parameter int          USER_WIDTH   = 8
) (
  input  logic                  TCK,
  input  logic                  TRST_N,
  input  logic                  TDI,
  input  logic                  tlr_st,
  input  logic                  cap_ir_st,
  input  logic                  sh_ir_st,
  input  logic                  upd_ir_st,
  input  logic                  cap_dr_st,
  input  logic                  sh_dr_st,
  input  logic                  upd_dr_st,
  input  logic [USER_WIDTH-1:0] USER_IN,
  output logic                  TDO,
  output logic                  TDO_EN,
  output logic [IR_WIDTH-1:0]   IR_Q,
  output logic [USER_WIDTH-1:0] USER_OUT,
  output logic                  USER_UPDATE
);

  localparam logic [IR_WIDTH-1:0] OP_IDCODE  = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] OP_USER    = IR_WIDTH'(2);
  // Capture_IR pattern: LSBs 01, upper bits zero (same bits as the IDCODE opcode)
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);

  logic [IR_WIDTH-1:0]   ir_sr;
  logic                  bypass;
  logic [31:0]           idcode_sr;
  logic [USER_WIDTH-1:0] user_sr;

  logic sel_idcode;
  logic sel_user;
  logic sel_bypass;
  logic dr_bit0;

  // Every opcode other than IDCODE and USER (including all-ones) selects BYPASS
  assign sel_idcode = (IR_Q == OP_IDCODE);
  assign sel_user   = (IR_Q == OP_USER);
  assign sel_bypass = !sel_idcode && !sel_user;

  always_comb begin
    dr_bit0 = bypass;
    if (sel_idcode)    dr_bit0 = idcode_sr[0];
    else if (sel_user) dr_bit0 = user_sr[0];
  end

  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      IR_Q        <= OP_IDCODE;
      ir_sr       <= '0;
      bypass      <= 1'b0;
      idcode_sr   <= '0;
      user_sr     <= '0;
      USER_OUT    <= '0;
      USER_UPDATE <= 1'b0;
    end else begin
      USER_UPDATE <= 1'b0;
      if (tlr_st) begin
        IR_Q <= OP_IDCODE;
      end else if (upd_ir_st || upd_dr_st) begin
        if (upd_ir_st) IR_Q <= ir_sr;
        if (upd_dr_st && sel_user) begin
          USER_OUT    <= user_sr;
          USER_UPDATE <= 1'b1;
        end
      end else if (cap_ir_st || cap_dr_st) begin
        if (cap_ir_st) ir_sr <= IR_CAPTURE;
        if (cap_dr_st) begin
          if (sel_idcode)    idcode_sr <= IDCODE_VALUE;
          else if (sel_user) user_sr   <= USER_IN;
          else               bypass    <= 1'b0;
        end
      end else if (sh_ir_st || sh_dr_st) begin
        if (sh_ir_st) ir_sr <= {TDI, ir_sr[IR_WIDTH-1:1]};
        if (sh_dr_st) begin
          // Written as shift-and-or so a 1-bit user register needs no special case
          if (sel_idcode)    idcode_sr <= {TDI, idcode_sr[31:1]};
          else if (sel_user) user_sr   <= (user_sr >> 1) | (USER_WIDTH'(TDI) << (USER_WIDTH-1));
          else               bypass    <= TDI;
        end
      end
    end
  end

  // Launch on the falling edge so TDO is settled before the next rising edge
  always_ff @(negedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      TDO    <= 1'b0;
      TDO_EN <= 1'b0;
    end else begin
      TDO    <= sh_ir_st ? ir_sr[0] : (sh_dr_st ? dr_bit0 : 1'b0);
      TDO_EN <= sh_ir_st | sh_dr_st;
    end
  end

  logic unused_sel;
  assign unused_sel = sel_bypass;

endmodule
